ripple_carry_24_bit: RTL and testbench

//  - WIDTH-bit (default 24) binary adder built as a ripple chain of 1-bit full adders.
//  - Computes {cout,sum} = a + b + cin.
//  - Serves the floating-point datapath as the mantissa adder (24 bits = hidden bit + 23-bit fraction).
//  - Operands are captured on the clock edge; sum/cout are registered outputs.

---
 rtl/fp_pkg.sv | 9 +
 rtl/full_adder.sv | 16 +
 rtl/ripple_carry_24_bit.sv | 57 +++++
 tb/tb_ripple_carry_24_bit.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// Shared definitions for the floating-point mantissa datapath.
// MANT_W covers the hidden bit plus the 23-bit fraction.
package fp_pkg;

    localparam int MANT_W = 24;

    typedef logic [MANT_W-1:0] mant_t;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell; purely combinational.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (cin & p);

endmodule

// File: rtl/ripple_carry_24_bit.sv
// Registered ripple-carry adder used as the mantissa adder: {cout,sum} = a + b + cin.
// The carry ripples through WIDTH full_adder cells; results appear one cycle after in_valid.
module ripple_carry_24_bit
    import fp_pkg::*;
#(
    parameter int WIDTH = MANT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             out_valid
);

    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    logic [WIDTH-1:0] sum_p1;
    logic             cout_p1;
    logic             vld_p1;

    assign c[0] = cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chain
        full_adder u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (s[i]),
            .cout (c[i+1])
        );
    end

    // ---- stage p0 -> p1: capture the rippled result; sum/cout hold while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p1  <= '0;
            cout_p1 <= 1'b0;
            vld_p1  <= 1'b0;
        end else begin
            vld_p1 <= in_valid;
            if (in_valid) begin
                sum_p1  <= s;
                cout_p1 <= c[WIDTH];
            end
        end
    end

    assign sum       = sum_p1;
    assign cout      = cout_p1;
    assign out_valid = vld_p1;

endmodule

// File: tb/tb_ripple_carry_24_bit.sv
// Directed and back-to-back checks for the registered 24-bit ripple-carry adder.
module tb_ripple_carry_24_bit;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [23:0] a;
    logic [23:0] b;
    logic        cin;
    logic [23:0] sum;
    logic        cout;
    logic        out_valid;

    int checks;
    int errors;

    ripple_carry_24_bit #(.WIDTH(24)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sum       (sum),
        .cout      (cout),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [23:0] va, input logic [23:0] vb, input logic vc);
        in_valid = v;
        a        = va;
        b        = vb;
        cin      = vc;
    endtask

    task automatic test_reset();
        // Inputs deliberately X: outputs must still come out of reset clean.
        rst_n = 1'b0;
        drive(1'bx, 'x, 'x, 1'bx);
        #2;
        checks++;
        if (sum !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_initial: got sum=%h cout=%b vld=%b want 000000 0 0", sum, cout, out_valid);
        end
        drive(1'b0, 24'h0, 24'h0, 1'b0);
        step();
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if (out_valid !== 1'b0 || sum !== 24'h0) begin
            errors++;
            $display("FAIL reset_release_idle: got sum=%h vld=%b want 000000 0", sum, out_valid);
        end
    endtask

    task automatic test_directed();
        logic [23:0] ta [5];
        logic [23:0] tb [5];
        logic        tc [5];
        logic [23:0] es [5];
        logic        ec [5];
        ta[0] = 24'h00001F; tb[0] = 24'h00000C; tc[0] = 1'b0; es[0] = 24'h00002B; ec[0] = 1'b0;
        ta[1] = 24'h00C61F; tb[1] = 24'h00018C; tc[1] = 1'b1; es[1] = 24'h00C7AC; ec[1] = 1'b0;
        ta[2] = 24'h00FFFF; tb[2] = 24'h000000; tc[2] = 1'b1; es[2] = 24'h010000; ec[2] = 1'b0;
        ta[3] = 24'hFFFFFF; tb[3] = 24'h000000; tc[3] = 1'b1; es[3] = 24'h000000; ec[3] = 1'b1;
        ta[4] = 24'hFFFFFF; tb[4] = 24'hFFFFFF; tc[4] = 1'b1; es[4] = 24'hFFFFFF; ec[4] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, ta[i], tb[i], tc[i]);
            step();
            checks++;
            if (sum !== es[i] || cout !== ec[i] || out_valid !== 1'b1) begin
                errors++;
                $display("FAIL directed_%0d: got sum=%h cout=%b vld=%b want %h %b 1",
                         i, sum, cout, out_valid, es[i], ec[i]);
            end
        end
        drive(1'b0, 24'h123456, 24'h654321, 1'b1);
        step();
        checks++;
        if (sum !== 24'hFFFFFF || cout !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL directed_idle_hold: got sum=%h cout=%b vld=%b want ffffff 1 0", sum, cout, out_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [23:0] ra;
        logic [23:0] rb;
        logic        rc;
        logic [24:0] exp;
        int          bad;
        bad = 0;
        exp = '0;
        for (int i = 0; i < 1000; i++) begin
            ra  = 24'($urandom);
            rb  = 24'($urandom);
            rc  = 1'($urandom);
            exp = {1'b0, ra} + {1'b0, rb} + {24'h0, rc};
            drive(1'b1, ra, rb, rc);
            step();
            checks++;
            if ({cout, sum} !== exp || out_valid !== 1'b1) begin
                errors++;
                bad++;
                if (bad <= 10)
                    $display("FAIL b2b_%0d: got %b_%h vld=%b want %b_%h 1",
                             i, cout, sum, out_valid, exp[24], exp[23:0]);
            end
        end
        drive(1'b0, 24'hA5A5A5, 24'h5A5A5A, 1'b1);
        step();
        checks++;
        if ({cout, sum} !== exp || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle: got %b_%h vld=%b want %b_%h 0", cout, sum, out_valid, exp[24], exp[23:0]);
        end
        step();
        checks++;
        if ({cout, sum} !== exp || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL b2b_idle2: got %b_%h vld=%b want %b_%h 0", cout, sum, out_valid, exp[24], exp[23:0]);
        end
    endtask

    task automatic test_reset_midstream();
        drive(1'b1, 24'h800000, 24'h800000, 1'b1);
        step();
        checks++;
        if (sum !== 24'h000001 || cout !== 1'b1 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_pre: got sum=%h cout=%b vld=%b want 000001 1 1", sum, cout, out_valid);
        end
        drive(1'b1, 24'h0F0F0F, 24'h010101, 1'b0);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (sum !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_async: got sum=%h cout=%b vld=%b want 000000 0 0", sum, cout, out_valid);
        end
        step();
        checks++;
        if (sum !== 24'h0 || cout !== 1'b0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold: got sum=%h cout=%b vld=%b want 000000 0 0", sum, cout, out_valid);
        end
        drive(1'b0, 24'h0F0F0F, 24'h010101, 1'b0);
        #3;
        rst_n = 1'b1;
        step();
        checks++;
        if (sum !== 24'h0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL mid_release: got sum=%h vld=%b want 000000 0", sum, out_valid);
        end
        drive(1'b1, 24'h0F0F0F, 24'h010101, 1'b0);
        step();
        checks++;
        if (sum !== 24'h101010 || cout !== 1'b0 || out_valid !== 1'b1) begin
            errors++;
            $display("FAIL mid_first: got sum=%h cout=%b vld=%b want 101010 0 1", sum, cout, out_valid);
        end
        drive(1'b0, 24'h0, 24'h0, 1'b0);
        step();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_directed();
        test_back_to_back();
        test_reset_midstream();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
